// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores bytes into a small TX FIFO that a serializer drains onto tx.
// Reads are combinational (zero latency); a store to a full FIFO is dropped and flagged, never stalled.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] data,
    output logic        tx,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [KW-1:0] CLK_LAST = KW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_enable;
    logic          r_irq_en;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [KW-1:0] r_clk_cnt;
    logic [KW-1:0] w_clk_cnt_nxt;
    logic [2:0]    r_bit_cnt;
    logic [2:0]    w_bit_cnt_nxt;
    logic          r_tx;
    logic          w_tx_nxt;

    logic w_sel;
    logic w_wr;
    logic w_push;
    logic w_pop;
    logic w_accept;
    logic w_drop;
    logic w_empty;
    logic w_full;
    logic w_bit_end;
    logic w_busy;
    logic w_unused;

    assign w_sel     = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr      = write_enable & w_sel;
    assign w_push    = w_wr & (addr[3:2] == 2'd0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    // A pop in the same cycle frees the slot the push lands in.
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & ~w_accept;
    assign w_bit_end = (r_clk_cnt == CLK_LAST);
    assign w_busy    = (r_state != S_IDLE);
    assign w_unused  = ^{addr[1:0], write_data[31:8]};

    assign tx  = r_tx;
    assign irq = r_irq_en & w_empty & ~w_busy;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A dropped push wins over a same-cycle clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && addr[3:2] == 2'd1 && write_data[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && addr[3:2] == 2'd2) begin
                r_enable <= write_data[0];
                r_irq_en <= write_data[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && r_bit_cnt == 3'd7) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Pop on the last stop cycle so the next start bit follows with no idle gap.
                if (w_bit_end) begin
                    if (r_enable && !w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_clk_cnt_nxt = (r_state == S_IDLE || w_bit_end) ? '0 : r_clk_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        if (r_state != S_DATA) begin
            w_bit_cnt_nxt = '0;
        end else if (w_bit_end) begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
        if (w_pop) begin
            w_shift_nxt = r_mem[r_rd_ptr];
        end else if (r_state == S_DATA && w_bit_end) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end
        // tx is registered from the upcoming state so it changes on the same edge as the FSM.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        data = '0;
        if (w_sel) begin
            case (addr[3:2])
                2'd1: begin
                    data[0]    = w_busy;
                    data[1]    = w_full;
                    data[2]    = w_empty;
                    data[3]    = r_ovf;
                    data[7+:8] = 8'(r_count);
                end
                2'd2:    data[1:0] = {r_irq_en, r_enable};
                default: data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus randomized bursts against a byte-queue model.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE     = 32'h0000_1000;
    localparam int          CPB      = 4;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] A_TXDATA = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;
    localparam int          FRAME    = 10 * CPB;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic [31:0] addr         = '0;
    logic [31:0] write_data   = '0;
    logic        write_enable = 1'b0;
    logic [31:0] data;
    logic        tx;
    logic        irq;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .write_data  (write_data),
        .write_enable(write_enable),
        .data        (data),
        .tx          (tx),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int          frames   = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input int busy, input int full, input int empty,
                                                input int ovf, input int cnt);
        return 32'(busy + 2 * full + 4 * empty + 8 * ovf + 128 * cnt);
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr         = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr         = a;
        write_enable = 1'b0;
        #1;
        d = data;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Line receiver: sample every cycle of a frame on the falling clock edge and decode the byte.
    initial begin : monitor
        logic [9:0]  bits;
        logic        aborted;
        int unsigned st;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st      = cyc;
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < CPB && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                        else if (s == 0) bits[b] = tx;
                        else check_eq("bit_stable", 32'(tx), 32'(bits[b]));
                    end
                end
                if (!aborted) begin
                    check_eq("stop_bit", 32'(bits[9]), 32'd1);
                    if (exp_q.size() == 0) check_eq("unexpected_frame", 32'(bits[8:1]), 32'hFFFF_FFFF);
                    else check_eq("rx_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
                    frames++;
                    start_q.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic [9:0]  frame;
        logic [7:0]  burst[5];
        logic [7:0]  b;
        logic [31:0] a;
        int          f0;
        int          n;
        int          cnt_m;
        int          ovf_m;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_STATUS, rd); check_eq("rst_status", rd, status_word(0, 0, 1, 0, 0));
        bus_read(A_CTRL, rd);   check_eq("rst_ctrl", rd, 32'd0);
        bus_read(A_TXDATA, rd); check_eq("rst_txdata_rd", rd, 32'd0);
        bus_read(A_RSVD, rd);   check_eq("rst_rsvd_rd", rd, 32'd0);

        // Single byte 0x55: exact waveform and busy timing
        bus_write(A_CTRL, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        exp_q.push_back(8'h55);
        bus_write(A_TXDATA, 32'h55);
        check_eq("t2_tx_before_pop", 32'(tx), 32'd1);
        addr = A_STATUS;
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("t2_tx_c%0d", k), 32'(tx), 32'(frame[k / CPB]));
            check_eq("t2_busy", 32'(data[0]), 32'd1);
            check_eq("t2_irq", 32'(irq), 32'd0);
        end
        @(posedge clk);
        #1;
        check_eq("t2_idle_status", data, status_word(0, 0, 1, 0, 0));

        // Overflow while disabled, then back-to-back drain
        bus_write(A_CTRL, 32'd0);
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 5; i++) begin
            bus_write(A_TXDATA, 32'(burst[i]));
            if (i < DEPTH) exp_q.push_back(burst[i]);
        end
        bus_read(A_STATUS, rd); check_eq("t3_full_status", rd, status_word(0, 1, 0, 1, 4));
        f0 = start_q.size();
        bus_write(A_CTRL, 32'd1);
        wait_drain(6 * FRAME);
        check_eq("t3_frames", 32'(start_q.size() - f0), 32'd4);
        if (start_q.size() >= f0 + 4) begin
            for (int i = 1; i < 4; i++)
                check_eq("t3_gap", start_q[f0 + i] - start_q[f0 + i - 1], 32'(FRAME));
        end
        repeat (60) @(posedge clk);
        check_eq("t3_no_extra_frame", 32'(start_q.size() - f0), 32'd4);
        bus_read(A_STATUS, rd); check_eq("t3_ovf_sticky", rd, status_word(0, 0, 1, 1, 0));
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, rd); check_eq("t3_ovf_clear", rd, status_word(0, 0, 1, 0, 0));

        // Out-of-window accesses
        bus_read(BASE + 32'h100, rd); check_eq("t4_rd_above", rd, 32'd0);
        bus_read(BASE - 32'h4, rd);   check_eq("t4_rd_below", rd, 32'd0);
        bus_write(BASE + 32'h108, 32'h3);
        bus_write(BASE + 32'h100, 32'hAA);
        bus_write(BASE - 32'h8, 32'h0);
        bus_write(BASE + 32'h104, 32'h8);
        bus_read(A_CTRL, rd);   check_eq("t4_ctrl_kept", rd, 32'd1);
        bus_read(A_STATUS, rd); check_eq("t4_status_kept", rd, status_word(0, 0, 1, 0, 0));

        // Push on the exact pop cycle with the FIFO full
        bus_write(A_CTRL, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'hA1 + 8'(i));
            bus_write(A_TXDATA, 32'hA1 + 32'(i));
        end
        bus_write(A_CTRL, 32'd1);
        exp_q.push_back(8'hA5);
        bus_write(A_TXDATA, 32'hA5);
        addr = A_STATUS;
        #1;
        check_eq("t5_idle_pop_push", data, status_word(1, 1, 0, 0, 4));
        repeat (FRAME - 1) @(posedge clk);
        exp_q.push_back(8'hA6);
        bus_write(A_TXDATA, 32'hA6);
        addr = A_STATUS;
        #1;
        check_eq("t5_stop_pop_push", data, status_word(1, 1, 0, 0, 4));
        check_eq("t5_next_start_tx", 32'(tx), 32'd0);
        wait_drain(7 * FRAME);
        bus_read(A_STATUS, rd); check_eq("t5_final_status", rd, status_word(0, 0, 1, 0, 0));

        // Asynchronous reset in the middle of a low data bit
        exp_q.push_back(8'h00);
        bus_write(A_TXDATA, 32'h0);
        repeat (10) @(posedge clk);
        #3;
        check_eq("t6_tx_low_pre_rst", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_tx_async_high", 32'(tx), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_STATUS, rd); check_eq("t6_status", rd, status_word(0, 0, 1, 0, 0));
        bus_read(A_CTRL, rd);   check_eq("t6_ctrl", rd, 32'd0);
        check_eq("t6_irq", 32'(irq), 32'd0);
        check_eq("t6_tx", 32'(tx), 32'd1);

        // Disable mid-frame, irq, queued byte retained
        bus_write(A_CTRL, 32'd3);
        check_eq("t7_irq_idle", 32'(irq), 32'd1);
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        bus_write(A_TXDATA, 32'(b));
        check_eq("t7_irq_pending", 32'(irq), 32'd0);
        repeat (12) @(posedge clk);
        bus_write(A_CTRL, 32'd2);
        check_eq("t7_irq_midframe", 32'(irq), 32'd0);
        wait_drain(2 * FRAME);
        check_eq("t7_irq_done", 32'(irq), 32'd1);
        bus_write(A_TXDATA, 32'h3C);
        bus_read(A_STATUS, rd); check_eq("t7_queued", rd, status_word(0, 0, 0, 0, 1));
        check_eq("t7_irq_queued", 32'(irq), 32'd0);
        f0 = start_q.size();
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (k % 10 == 0) check_eq("t7_tx_idle", 32'(tx), 32'd1);
        end
        check_eq("t7_no_frame", 32'(start_q.size() - f0), 32'd0);
        bus_read(A_STATUS, rd); check_eq("t7_still_queued", rd, status_word(0, 0, 0, 0, 1));
        exp_q.push_back(8'h3C);
        bus_write(A_CTRL, 32'd1);
        wait_drain(2 * FRAME);

        // Randomized bursts against the queue model
        for (int r = 0; r < 6; r++) begin
            bus_write(A_CTRL, 32'd0);
            bus_write(A_STATUS, 32'h8);
            cnt_m = 0;
            ovf_m = 0;
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = BASE + 32'(16 * $urandom_range(1, 255)) + 32'($urandom_range(0, 15));
                    bus_write(a, $urandom);
                end
                b = 8'($urandom);
                bus_write(A_TXDATA, {24'($urandom), b});
                if (cnt_m < DEPTH) begin
                    cnt_m++;
                    exp_q.push_back(b);
                end else begin
                    ovf_m = 1;
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                bus_write(A_STATUS, 32'hFFFF_FFFF);
                ovf_m = 0;
            end
            bus_read(A_STATUS, rd);
            check_eq("rnd_status", rd, status_word(0, (cnt_m == DEPTH) ? 1 : 0, (cnt_m == 0) ? 1 : 0, ovf_m, cnt_m));
            bus_read(A_TXDATA, rd); check_eq("rnd_txdata_rd", rd, 32'd0);
            bus_read(A_RSVD, rd);   check_eq("rnd_rsvd_rd", rd, 32'd0);
            bus_write(A_CTRL, 32'd1);
            wait_drain(DEPTH * FRAME + 20);
            bus_read(A_STATUS, rd);
            check_eq("rnd_drained", rd, status_word(0, 0, 1, ovf_m, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus.
- Responder side of the bus the single-cycle `cpu` drives: `addr`, `write_data`, `write_enable`, read `data`. It is a sibling of `simple_ram`, selected by an address window.
- CPU stores bytes into a small TX FIFO. An 8N1 serializer drains the FIFO onto `tx`.
- Reads are combinational, so the single-cycle CPU completes loads in the same cycle.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of 16-byte register window; bits [3:0] must be 0.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  32  bus byte address.
- write_data  input  32  store data.
- write_enable  input  1  store strobe; sampled at clk rising edge.
- data  output  32  read data, combinational from addr and current state.
- tx  output  1  serial line; idle high.
- irq  output  1  high when CTRL.irq_en=1 and FIFO empty and FSM IDLE.

Behaviour:
- Select: sel = (addr[31:4] == BASE_ADDR[31:4]).
- Register offsets are decoded from addr[3:2]. addr[1:0] is ignored.
- 0x0 TXDATA
  - Write pushes write_data[7:0].
  - Read returns 0.
- 0x4 STATUS (read)
  - bit0 busy (FSM != IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow (sticky)
  - bits[7+:8] FIFO count
  - other bits 0
  - Writing 1 to bit3 clears overflow. Other written bits are ignored.
- 0x8 CTRL (read/write)
  - bit0 enable
  - bit1 irq_en
  - Other bits read 0.
- 0xC: reads 0, writes ignored.
- sel=0: data=32'h0; writes have no effect.
- Writes take effect at the clk edge where write_enable=1 and sel=1. Reads reflect state after the most recent edge.
- Reset (async, immediate):
  - tx=1, FIFO emptied (count 0), overflow=0, CTRL=0, FSM=IDLE, bit/clk counters=0, irq=0.
  - Reset mid-frame aborts the frame; tx goes high without waiting for the clock.
- FIFO:
  - Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (count unchanged).
  - Otherwise the push is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is FIFO_DEPTH=full, 0=empty.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If enable=1 and FIFO not empty, pop the head into the shift register and go to START next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, 8 bits, shifting right after each bit. Then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - Then IDLE.
    - At STOP end, if enable=1 and FIFO not empty, the pop happens in the last STOP cycle and the next START begins back-to-back. No extra idle cycle.
- Frame length: exactly 10*CLKS_PER_BIT cycles of tx.
  - Gap between the write edge and tx falling: 1 cycle (IDLE pop edge) when idle.
- tx is registered (no glitches).
- Clearing enable mid-frame: the current frame completes; no further pops.
- FIFO contents are retained while disabled.
- Simultaneous STATUS overflow-clear write and a dropped push in the same cycle: overflow ends set.

Test Plan:
- Reset with CLKS_PER_BIT=4, FIFO_DEPTH=4; release; then write CTRL=1 and TXDATA=0x55.
  - tx goes low 1 cycle after the write edge and stays low 4 cycles.
  - Data bits follow as 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - STATUS.busy=1 during the frame and 0 after 40 cycles; irq stays 0 since irq_en=0.
- CTRL=0; write 0x11,0x22,0x33,0x44,0x66.
  - STATUS reads full=1, count=4, overflow=1.
  - Set CTRL=1: tx emits 0x11,0x22,0x33,0x44 back-to-back (160 cycles, no idle between frames). 0x66 never appears.
  - Write STATUS=0x8 -> overflow=0.
- Read addr=BASE_ADDR+0x100 and BASE_ADDR-4 -> data=0. Writes there leave STATUS/CTRL unchanged.
- FIFO full and transmitting; write TXDATA on the exact cycle of a pop.
  - Push accepted, count stays 4, overflow=0.
  - The byte is transmitted in order.
- Assert rst_n=0 midway through a DATA bit with tx=0.
  - tx=1 before the next clk edge.
  - After release: STATUS=0x4 (empty only), CTRL=0.
- CTRL=3, send one byte; clear enable (CTRL=2) mid-frame.
  - Frame completes intact; irq rises once the FSM returns to IDLE with the FIFO empty.
  - A byte written afterwards stays queued (count=1) with tx=1 until enable is set again.
